// File: rtl/slurmboy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slurmboy_pkg
//  Description : Shared constants for the slurmboy memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package slurmboy_pkg;

    // Owner encoding on gnt_id
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_DISP = 2'd1;
    localparam logic [1:0] GNT_AUD  = 2'd2;
    localparam logic [1:0] GNT_CPU  = 2'd3;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage : slurmboy_pkg
`default_nettype wire

// File: rtl/slurmboy_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : slurmboy_mem_arbiter_if
//  Description : Requester and external-memory signals of the memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface slurmboy_mem_arbiter_if #(
    parameter int ADDR_W = 22
);
    logic              cpu_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wstrb;
    logic              cpu_ready;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic              aud_req;
    logic [ADDR_W-1:0] aud_addr;
    logic              aud_ack;
    logic [31:0]       rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic [1:0]        gnt_id;

    // slave: the arbiter itself; master: requesters plus external memory
    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        input  disp_req, disp_addr, aud_req, aud_addr, mem_rdata,
        output cpu_ready, disp_ack, aud_ack, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, gnt_id
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        output disp_req, disp_addr, aud_req, aud_addr, mem_rdata,
        input  cpu_ready, disp_ack, aud_ack, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, gnt_id
    );
endinterface : slurmboy_mem_arbiter_if
`default_nettype wire

// File: rtl/slurmboy_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : slurmboy_mem_arbiter
//  Description : Shares the external memory port between display, audio and
//                CPU with fixed-latency accesses and a CPU starvation guard.
//  Revision    : 1.0  initial release
// ============================================================================
module slurmboy_mem_arbiter
    import slurmboy_pkg::*;
#(
    parameter int ADDR_W       = 22,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    slurmboy_mem_arbiter_if.slave  bus
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic [SC_W-1:0]   r_starve_cnt;
    logic [1:0]        r_gnt_id;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_wstrb;
    logic [31:0]       r_rdata;
    logic              r_cpu_ready;
    logic              r_disp_ack;
    logic              r_aud_ack;

    logic              w_starved;
    logic [1:0]        w_winner;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [3:0]        w_sel_wstrb;
    logic              w_sel_we;

    // Priority pick: starved CPU > display > audio > CPU
    always_comb begin
        w_starved   = bus.cpu_valid && (r_starve_cnt == SC_W'(STARVE_LIMIT));
        w_winner    = GNT_NONE;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        w_sel_we    = 1'b0;
        if (w_starved) begin
            w_winner = GNT_CPU;
        end else if (bus.disp_req) begin
            w_winner = GNT_DISP;
        end else if (bus.aud_req) begin
            w_winner = GNT_AUD;
        end else if (bus.cpu_valid) begin
            w_winner = GNT_CPU;
        end
        case (w_winner)
            GNT_DISP: w_sel_addr = bus.disp_addr;
            GNT_AUD:  w_sel_addr = bus.aud_addr;
            GNT_CPU: begin
                w_sel_addr  = bus.cpu_addr;
                w_sel_wdata = bus.cpu_wdata;
                w_sel_wstrb = bus.cpu_wstrb;
                w_sel_we    = |bus.cpu_wstrb;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_gnt_id     <= GNT_NONE;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_rdata      <= '0;
            r_cpu_ready  <= 1'b0;
            r_disp_ack   <= 1'b0;
            r_aud_ack    <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_disp_ack  <= 1'b0;
            r_aud_ack   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_gnt_id    <= w_winner;
                    r_mem_addr  <= w_sel_addr;
                    r_mem_wdata <= w_sel_wdata;
                    r_mem_wstrb <= w_sel_wstrb;
                    r_mem_we    <= w_sel_we;
                    r_mem_en    <= (w_winner != GNT_NONE);
                    r_lat_cnt   <= CNT_W'(MEM_LAT - 1);
                    if (w_winner != GNT_NONE) begin
                        r_state <= ST_ACCESS;
                    end
                    // Counter only grows while a waiting CPU keeps losing
                    if ((w_winner == GNT_CPU) || !bus.cpu_valid) begin
                        r_starve_cnt <= '0;
                    end else if (r_starve_cnt != SC_W'(STARVE_LIMIT)) begin
                        r_starve_cnt <= r_starve_cnt + SC_W'(1);
                    end
                end
                ST_ACCESS: begin
                    if (r_lat_cnt == '0) begin
                        r_rdata     <= bus.mem_rdata;
                        r_mem_en    <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_cpu_ready <= (r_gnt_id == GNT_CPU);
                        r_disp_ack  <= (r_gnt_id == GNT_DISP);
                        r_aud_ack   <= (r_gnt_id == GNT_AUD);
                        r_state     <= ST_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_gnt_id    <= GNT_NONE;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_mem_wstrb <= '0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt_id    = r_gnt_id;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign bus.rdata     = r_rdata;
    assign bus.cpu_ready = r_cpu_ready;
    assign bus.disp_ack  = r_disp_ack;
    assign bus.aud_ack   = r_aud_ack;

endmodule : slurmboy_mem_arbiter
`default_nettype wire
